// File: rtl/uart_pkg.sv
// Shared UART definitions for the score link: packet header, transmit FSM states
// and the byte packing of the two player scores.
package uart_pkg;

    localparam logic [7:0] SCORE_HEADER = 8'hA5;
    localparam int         PACKET_BYTES = 2;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } tx_state_e;

    function automatic logic [7:0] pack_scores(input logic [3:0] p1, input logic [3:0] p2);
        return {p1, p2};
    endfunction

endpackage

// File: rtl/score_link_tx_if.sv
// Score link signal bundle: local scores and resend request in, UART line and busy out.
interface score_link_tx_if;

    logic [3:0] player1_score;
    logic [3:0] player2_score;
    logic       resend;
    logic       tx;
    logic       busy;

    modport master (
        output player1_score,
        output player2_score,
        output resend,
        input  tx,
        input  busy
    );

    modport slave (
        input  player1_score,
        input  player2_score,
        input  resend,
        output tx,
        output busy
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter with a registered line output; a new start is accepted
// in the cycle done pulses so consecutive bytes leave with no idle gap.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 564
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int            CW       = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done    = 1'b0;
        bit_end = (cyc_q == CYC_LAST);

        if (state_q != IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + 1'b1;
        end

        unique case (state_q)
            START_BIT: begin
                if (bit_end) begin
                    state_d = DATA_BITS;
                    tx_d    = shift_q[0];
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A start on the last stop-bit cycle chains straight into the next start bit.
        if (start && (state_q == IDLE || done)) begin
            state_d = START_BIT;
            shift_d = data;
            bit_d   = '0;
            cyc_d   = '0;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            // NOTE: the shift register is reset too, keeping the whole state deterministic after rst.
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: rtl/score_link_tx.sv
// Score link transmitter: detects score changes or resend requests and sends a
// header byte plus the packed scores, queuing at most one packet while busy.
module score_link_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 65_000_000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD
) (
    input  logic            clk,
    input  logic            rst,
    score_link_tx_if.slave  link
);

    localparam logic LAST_IDX = 1'(PACKET_BYTES - 1);

    logic [7:0] live_scores;
    logic [7:0] last_sent_q, last_sent_d;
    logic [7:0] snap_q, snap_d;
    logic       pending_q, pending_d;
    logic       byte_idx_q, byte_idx_d;
    logic       trig, launch;
    logic       byte_start, byte_done, byte_busy, byte_tx;
    logic [7:0] byte_data;

    always_comb begin
        live_scores = pack_scores(link.player1_score, link.player2_score);
        trig        = link.resend | (live_scores != last_sent_q);
        launch      = !byte_busy && (trig || pending_q);

        last_sent_d = last_sent_q;
        snap_d      = snap_q;
        pending_d   = pending_q;
        byte_idx_d  = byte_idx_q;

        if (launch) begin
            snap_d      = live_scores;
            last_sent_d = live_scores;
            pending_d   = 1'b0;
            byte_idx_d  = '0;
        end else if (byte_busy && trig) begin
            // Any number of triggers while busy collapse into a single follow-up packet.
            pending_d = 1'b1;
        end

        if (byte_done && byte_idx_q != LAST_IDX) begin
            byte_idx_d = byte_idx_q + 1'b1;
        end

        byte_start = launch || (byte_done && byte_idx_q != LAST_IDX);
        byte_data  = launch ? SCORE_HEADER : snap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sent_q <= 8'h00;
            snap_q      <= 8'h00;
            pending_q   <= 1'b0;
            byte_idx_q  <= 1'b0;
        end else begin
            last_sent_q <= last_sent_d;
            snap_q      <= snap_d;
            pending_q   <= pending_d;
            byte_idx_q  <= byte_idx_d;
        end
    end

    uart_tx_byte #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (byte_tx),
        .done  (byte_done),
        .busy  (byte_busy)
    );

    assign link.tx   = byte_tx;
    assign link.busy = byte_busy;

endmodule

// File: tb/tb_score_link_tx.sv
// Bench for score_link_tx: packet-timeline reference model, UART line decoder,
// table-driven trigger vectors, hand-written corner cases and a random run.
module tb_score_link_tx;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BC       = CLK_FREQ / BAUD;
    localparam int PKT      = 20 * BC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_link_tx_if link();

    score_link_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a packet is a 20-bit frame held for BC cycles per bit.
    int         m_left    = 0;
    logic [19:0] m_pkt    = '1;
    logic [7:0] m_last    = 8'h00;
    logic       m_pending = 1'b0;
    logic [7:0] exp_q[$];

    function automatic logic [19:0] frame_bits(input logic [7:0] b1);
        return {1'b1, b1, 1'b0, 1'b1, SCORE_HEADER, 1'b0};
    endfunction

    task automatic model_eval();
        logic [7:0] live;
        logic       trig;
        if (rst) begin
            m_left = 0; m_last = 8'h00; m_pending = 1'b0;
            return;
        end
        live = {link.player1_score, link.player2_score};
        trig = link.resend || (live != m_last);
        if (m_left > 0) begin
            if (trig) m_pending = 1'b1;
            m_left--;
        end else if (trig || m_pending) begin
            m_pkt = frame_bits(live);
            m_left = PKT;
            m_last = live;
            m_pending = 1'b0;
            exp_q.push_back(live);
        end
    endtask

    function automatic int m_tx();
        if (m_left == 0) return 1;
        return int'(m_pkt[(PKT - m_left) / BC]);
    endfunction

    // Line decoder: samples each bit at its centre.
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_sh     = 8'h00;
    int         frame_errs = 0;
    logic [7:0] rx_q[$];

    task automatic monitor();
        int idx;
        if (rst) begin
            mon_active = 1'b0;
            return;
        end
        if (!mon_active) begin
            if (link.tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % BC == BC / 2) begin
                idx = mon_cnt / BC;
                if (idx == 0) begin
                    if (link.tx != 1'b0) mon_active = 1'b0;
                end else if (idx <= 8) begin
                    mon_sh[idx-1] = link.tx;
                end else begin
                    if (link.tx !== 1'b1) frame_errs++;
                    else rx_q.push_back(mon_sh);
                    mon_active = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        check("tx_cycle", int'(link.tx), m_tx());
        check("busy_cycle", int'(link.busy), int'(m_left > 0));
        monitor();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((link.busy || m_pending || m_left > 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", int'(n < budget), 1);
        tick();
        tick();
    endtask

    task automatic expect_pkt(input string name, input logic [7:0] b1);
        if (rx_q.size() < 2) begin
            check({name, "_count"}, rx_q.size(), 2);
        end else begin
            check({name, "_hdr"}, int'(rx_q.pop_front()), int'(SCORE_HEADER));
            check({name, "_b1"}, int'(rx_q.pop_front()), int'(b1));
        end
    endtask

    typedef struct {
        logic [3:0] p1;
        logic [3:0] p2;
        logic       resend;
        logic       exp_pkt;
        logic [7:0] exp_b1;
    } vec_t;

    vec_t vecs[7];
    logic samples[PKT];
    logic [19:0] ref_bits;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;

        vecs[0] = '{4'd9,  4'd7,  1'b0, 1'b1, 8'h97};
        vecs[1] = '{4'd9,  4'd7,  1'b1, 1'b1, 8'h97};
        vecs[2] = '{4'd9,  4'd8,  1'b1, 1'b1, 8'h98};
        vecs[3] = '{4'd9,  4'd8,  1'b0, 1'b0, 8'h00};
        vecs[4] = '{4'd15, 4'd10, 1'b0, 1'b1, 8'hFA};
        vecs[5] = '{4'd0,  4'd0,  1'b0, 1'b1, 8'h00};
        vecs[6] = '{4'd0,  4'd0,  1'b1, 1'b1, 8'h00};

        link.player1_score = 4'd0;
        link.player2_score = 4'd0;
        link.resend = 1'b0;

        // Reset, then 500 quiet cycles with scores at zero.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_tx", int'(link.tx), 1);
        check("reset_busy", int'(link.busy), 0);
        repeat (500) tick();
        check("quiet_no_packet", rx_q.size(), 0);

        // One-cycle launch latency and 200-cycle packet length.
        link.player1_score = 4'd3;
        tick();
        check("latency_tx", int'(link.tx), 0);
        check("latency_busy", int'(link.busy), 1);
        n = 1;
        while (link.busy && n < 400) begin
            tick();
            n++;
        end
        check("busy_drop_cycle", n, 201);
        wait_idle(400);
        expect_pkt("first_pkt", 8'h30);

        // Scores change mid-packet: frozen snapshot, then one collapsed pending packet.
        link.player1_score = 4'd1;
        tick();
        repeat (49) tick();
        link.player1_score = 4'd2;
        repeat (60) tick();
        link.player1_score = 4'd3;
        n = 0;
        while (link.busy && n < 400) begin
            tick();
            n++;
        end
        check("gap_idle_busy", int'(link.busy), 0);
        check("gap_idle_tx", int'(link.tx), 1);
        tick();
        check("gap_relaunch_busy", int'(link.busy), 1);
        check("gap_relaunch_tx", int'(link.tx), 0);
        wait_idle(400);
        expect_pkt("frozen_pkt", 8'h10);
        expect_pkt("pending_pkt", 8'h30);
        check("pending_single", rx_q.size(), 0);

        // Table of trigger vectors, each given time to drain.
        for (int i = 0; i < 7; i++) begin
            link.player1_score = vecs[i].p1;
            link.player2_score = vecs[i].p2;
            link.resend = vecs[i].resend;
            tick();
            link.resend = 1'b0;
            wait_idle(600);
            if (vecs[i].exp_pkt) expect_pkt($sformatf("vec%0d", i), vecs[i].exp_b1);
            check($sformatf("vec%0d_extra", i), rx_q.size(), 0);
        end

        // Reset during data bit 5 of byte 1.
        link.player1_score = 4'd5;
        tick();
        repeat (10 * (10 + 1 + 5) + 5) tick();
        rst = 1'b1;
        link.player1_score = 4'd0;
        tick();
        check("midrst_tx", int'(link.tx), 1);
        check("midrst_busy", int'(link.busy), 0);
        rst = 1'b0;
        rx_q.delete();
        repeat (20) tick();
        check("midrst_quiet", rx_q.size(), 0);
        link.player2_score = 4'd1;
        tick();
        wait_idle(400);
        expect_pkt("post_rst_pkt", 8'h01);

        // Bit widths across one packet.
        link.player2_score = 4'd2;
        for (int i = 0; i < PKT; i++) begin
            tick();
            samples[i] = link.tx;
        end
        ref_bits = frame_bits(8'h02);
        for (int k = 0; k < 20; k++) begin
            cnt = 0;
            for (int j = 0; j < BC; j++) if (samples[k*BC + j] === ref_bits[k]) cnt++;
            check($sformatf("bit%0d_width", k), cnt, BC);
        end
        check("byte0_stop_end", int'(samples[10*BC - 1]), 1);
        check("byte1_start_begin", int'(samples[10*BC]), 0);
        wait_idle(400);
        expect_pkt("width_pkt", 8'h02);

        // Random score changes and resend pulses against the model.
        exp_q.delete();
        rx_q.delete();
        for (int c = 0; c < 3000; c++) begin
            n = int'($urandom_range(0, 99));
            if (n < 2) link.player1_score = 4'($urandom_range(0, 15));
            else if (n < 4) link.player2_score = 4'($urandom_range(0, 15));
            link.resend = ($urandom_range(0, 79) == 0);
            tick();
            link.resend = 1'b0;
        end
        wait_idle(1000);
        check("rand_pkt_count", rx_q.size(), 2 * exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() >= 2) expect_pkt("rand_pkt", exp_q.pop_front());
        check("frame_errors", frame_errs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
